// File: rtl/timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | timer_ctrl : button-driven sequencer for a 4-digit BCD MM:SS countdown     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module timer_ctrl #(
  parameter logic [15:0] PRESET_DEFAULT = 16'h0100,
  parameter int unsigned ALARM_TICKS    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_btn_start,
  input  logic        i_btn_mode,
  input  logic        i_btn_inc,
  input  logic        i_zero,
  output logic        o_load,
  output logic [15:0] o_preset,
  output logic        o_cnt_en,
  output logic [3:0]  o_blank,
  output logic        o_alarm,
  output logic [2:0]  o_state
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_SET_MIN = 3'd1;
  localparam logic [2:0] c_SET_SEC = 3'd2;
  localparam logic [2:0] c_RUN     = 3'd3;
  localparam logic [2:0] c_PAUSE   = 3'd4;
  localparam logic [2:0] c_ALARM   = 3'd5;

  localparam int unsigned       c_ACW        = (ALARM_TICKS < 2) ? 1 : $clog2(ALARM_TICKS + 1);
  localparam logic [c_ACW-1:0]  c_ALARM_INIT = c_ACW'(ALARM_TICKS);
  localparam logic [c_ACW-1:0]  c_ACNT_ONE   = c_ACW'(1);

  logic [2:0]       r_state;
  logic [15:0]      r_preset;
  logic             r_ph;
  logic [c_ACW-1:0] r_acnt;
  logic             r_load;
  logic [3:0]       r_blank;
  logic             r_alarm;

  logic [2:0]       w_next_state;
  logic [15:0]      w_next_preset;
  logic [c_ACW-1:0] w_next_acnt;
  logic             w_next_ph;
  logic [3:0]       w_next_blank;
  logic             w_preset_zero;
  logic             w_any_btn;

  // Two-digit BCD increment that wraps 59 -> 00.
  function automatic logic [7:0] f_bcd_inc59(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  assign w_preset_zero = (r_preset == 16'h0000);
  assign w_any_btn     = i_btn_start | i_btn_mode | i_btn_inc;

  always_comb begin
    w_next_state  = r_state;
    w_next_preset = r_preset;
    w_next_acnt   = r_acnt;
    case (r_state)
      c_IDLE: begin
        if (i_btn_start) begin
          if (!w_preset_zero) w_next_state = c_RUN;
        end else if (i_btn_mode) begin
          w_next_state = c_SET_MIN;
        end
      end
      c_SET_MIN: begin
        if (i_btn_start)      w_next_state = c_IDLE;
        else if (i_btn_mode)  w_next_state = c_SET_SEC;
        else if (i_btn_inc)   w_next_preset[15:8] = f_bcd_inc59(r_preset[15:8]);
      end
      c_SET_SEC: begin
        if (i_btn_start || i_btn_mode) w_next_state = c_IDLE;
        else if (i_btn_inc)            w_next_preset[7:0] = f_bcd_inc59(r_preset[7:0]);
      end
      c_RUN: begin
        // Expiry outranks a pause request arriving in the same cycle.
        if (i_zero) begin
          w_next_state = c_ALARM;
          w_next_acnt  = c_ALARM_INIT;
        end else if (i_btn_start) begin
          w_next_state = c_PAUSE;
        end
      end
      c_PAUSE: begin
        if (i_btn_start)     w_next_state = c_RUN;
        else if (i_btn_mode) w_next_state = c_IDLE;
      end
      c_ALARM: begin
        if (w_any_btn) begin
          w_next_state = c_IDLE;
        end else if (i_tick) begin
          if (r_acnt <= c_ACNT_ONE) begin
            w_next_acnt  = '0;
            w_next_state = c_IDLE;
          end else begin
            w_next_acnt = r_acnt - c_ACNT_ONE;
          end
        end
      end
      default: w_next_state = c_IDLE;
    endcase
  end

  // Phase restarts at 0 on any state change so freshly entered modes show digits.
  assign w_next_ph = (w_next_state != r_state) ? 1'b0 : (r_ph ^ i_tick);

  always_comb begin
    w_next_blank = 4'b0000;
    case (w_next_state)
      c_SET_MIN:       w_next_blank = {w_next_ph, w_next_ph, 2'b00};
      c_SET_SEC:       w_next_blank = {2'b00, w_next_ph, w_next_ph};
      c_PAUSE, c_ALARM: w_next_blank = {4{w_next_ph}};
      default:         w_next_blank = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_preset <= PRESET_DEFAULT;
      r_ph     <= 1'b0;
      r_acnt   <= '0;
      r_load   <= 1'b1;
      r_blank  <= 4'b0000;
      r_alarm  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_preset <= w_next_preset;
      r_ph     <= w_next_ph;
      r_acnt   <= w_next_acnt;
      r_load   <= (w_next_state == c_IDLE) || (w_next_state == c_SET_MIN) ||
                  (w_next_state == c_SET_SEC);
      r_blank  <= w_next_blank;
      r_alarm  <= (w_next_state == c_ALARM);
    end
  end

  assign o_load   = r_load;
  assign o_preset = r_preset;
  assign o_cnt_en = (r_state == c_RUN) & i_tick & ~i_zero;
  assign o_blank  = r_blank;
  assign o_alarm  = r_alarm;
  assign o_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_timer_ctrl : directed scoreboard bench for timer_ctrl                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_timer_ctrl;

  localparam int c_TICKS = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_tick, i_btn_start, i_btn_mode, i_btn_inc, i_zero;
  logic        o_load, o_cnt_en, o_alarm;
  logic [15:0] o_preset;
  logic [3:0]  o_blank;
  logic [2:0]  o_state;

  timer_ctrl #(.PRESET_DEFAULT(16'h0100), .ALARM_TICKS(c_TICKS)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_btn_start(i_btn_start),
    .i_btn_mode(i_btn_mode), .i_btn_inc(i_btn_inc), .i_zero(i_zero),
    .o_load(o_load), .o_preset(o_preset), .o_cnt_en(o_cnt_en),
    .o_blank(o_blank), .o_alarm(o_alarm), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [15:0] pre;
    logic        ld;
    logic [3:0]  bl;
    logic        al;
  } exp_t;
  exp_t sb[$];

  // Reference model kept in plain integers (minutes/seconds as 0..59).
  int   m_st, m_min, m_sec, m_acnt;
  logic m_ph;
  logic z_lvl;

  function automatic logic [15:0] to_bcd(input int mi, input int se);
    return {4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic model(input string tag, input logic t, input logic s, input logic m,
                       input logic inc, input logic z);
    int   ns, na;
    exp_t e;
    ns = m_st;
    na = m_acnt;
    case (m_st)
      0: if (s) begin if (m_min != 0 || m_sec != 0) ns = 3; end else if (m) ns = 1;
      1: if (s) ns = 0; else if (m) ns = 2; else if (inc) m_min = (m_min + 1) % 60;
      2: if (s || m) ns = 0; else if (inc) m_sec = (m_sec + 1) % 60;
      3: if (z) begin ns = 5; na = c_TICKS; end else if (s) ns = 4;
      4: if (s) ns = 3; else if (m) ns = 0;
      5: if (s || m || inc) ns = 0;
         else if (t) begin na = m_acnt - 1; if (na == 0) ns = 0; end
      default: ns = 0;
    endcase
    m_ph   = (ns != m_st) ? 1'b0 : (t ? ~m_ph : m_ph);
    m_st   = ns;
    m_acnt = na;
    e.tag = tag;
    e.st  = 3'(m_st);
    e.pre = to_bcd(m_min, m_sec);
    e.ld  = (m_st <= 2);
    e.al  = (m_st == 5);
    case (m_st)
      1:       e.bl = {m_ph, m_ph, 2'b00};
      2:       e.bl = {2'b00, m_ph, m_ph};
      4, 5:    e.bl = {4{m_ph}};
      default: e.bl = 4'b0000;
    endcase
    sb.push_back(e);
  endtask

  task automatic step(input string tag, input logic t, input logic s, input logic m,
                      input logic inc);
    exp_t e;
    logic exp_en;
    i_tick = t; i_btn_start = s; i_btn_mode = m; i_btn_inc = inc; i_zero = z_lvl;
    #1;
    exp_en = (m_st == 3) && t && !z_lvl;
    chk({tag, ".cnt_en"}, 16'(o_cnt_en), 16'(exp_en));
    model(tag, t, s, m, inc, z_lvl);
    @(posedge clk);
    #1;
    i_tick = 0; i_btn_start = 0; i_btn_mode = 0; i_btn_inc = 0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, o_state);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".state"},  16'(o_state), 16'(e.st));
      chk({e.tag, ".preset"}, o_preset,     e.pre);
      chk({e.tag, ".load"},   16'(o_load),  16'(e.ld));
      chk({e.tag, ".blank"},  16'(o_blank), 16'(e.bl));
      chk({e.tag, ".alarm"},  16'(o_alarm), 16'(e.al));
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    i_tick = 0; i_btn_start = 0; i_btn_mode = 0; i_btn_inc = 0; i_zero = 0; z_lvl = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 0;
    m_st = 0; m_min = 1; m_sec = 0; m_ph = 0; m_acnt = 0;
    chk("rst.state",  16'(o_state),  16'h0000);
    chk("rst.preset", o_preset,      16'h0100);
    chk("rst.load",   16'(o_load),   16'h0001);
    chk("rst.cnt_en", 16'(o_cnt_en), 16'h0000);
    chk("rst.blank",  16'(o_blank),  16'h0000);
    chk("rst.alarm",  16'(o_alarm),  16'h0000);
  endtask

  initial begin
    // 1: reset, start, ticks decrement
    do_reset(2);
    step("start_run", 0, 1, 0, 0);
    chk("run.state", 16'(o_state), 16'h0003);
    chk("run.load",  16'(o_load),  16'h0000);
    for (int k = 0; k < 3; k++) begin
      step("run_tick", 1, 0, 0, 0);
      step("run_idle", 0, 0, 0, 0);
    end
    step("pause", 0, 1, 0, 0);
    step("to_idle", 0, 0, 1, 0);

    // 2: edit minutes with wrap, then seconds
    step("edit_min", 0, 0, 1, 0);
    step("min_blink1", 1, 0, 0, 0);
    chk("min_blink.blank", 16'(o_blank), 16'h000C);
    step("min_blink0", 1, 0, 0, 0);
    for (int k = 0; k < 60; k++) step("inc_min", 0, 0, 0, 1);
    chk("min_wrap.preset", o_preset, 16'h0100);
    step("edit_sec", 0, 0, 1, 0);
    step("sec_blink1", 1, 0, 0, 0);
    chk("sec_blink.blank", 16'(o_blank), 16'h0003);
    for (int k = 0; k < 3; k++) step("inc_sec", 0, 0, 0, 1);
    chk("sec.preset", o_preset, 16'h0103);
    step("sec_exit", 0, 0, 1, 0);
    chk("sec_exit.state", 16'(o_state), 16'h0000);

    // 3: preset 00:00 cannot start
    step("z_min", 0, 0, 1, 0);
    for (int k = 0; k < 59; k++) step("z_inc_min", 0, 0, 0, 1);
    step("z_sec", 0, 0, 1, 0);
    for (int k = 0; k < 57; k++) step("z_inc_sec", 0, 0, 0, 1);
    step("z_exit", 0, 0, 1, 0);
    chk("zero.preset", o_preset, 16'h0000);
    step("z_start", 0, 1, 0, 0);
    chk("z_start.state", 16'(o_state), 16'h0000);
    step("z_tick", 1, 0, 0, 0);
    step("r_min", 0, 0, 1, 0);
    step("r_inc", 0, 0, 0, 1);
    step("r_sec", 0, 0, 1, 0);
    step("r_exit", 0, 0, 1, 0);
    chk("restore.preset", o_preset, 16'h0100);

    // 4: expiry with coincident tick and start, alarm for ALARM_TICKS ticks
    step("a_start", 0, 1, 0, 0);
    step("a_tick", 1, 0, 0, 0);
    z_lvl = 1;
    step("a_expire", 1, 1, 0, 0);
    chk("alarm.state", 16'(o_state), 16'h0005);
    chk("alarm.out",   16'(o_alarm), 16'h0001);
    for (int k = 0; k < c_TICKS; k++) begin
      step("a_idle", 0, 0, 0, 0);
      step("a_tick", 1, 0, 0, 0);
    end
    chk("alarm_done.state", 16'(o_state), 16'h0000);
    chk("alarm_done.load",  16'(o_load),  16'h0001);
    z_lvl = 0;

    // 5: pause / resume / cancel
    step("p_start", 0, 1, 0, 0);
    step("p_pause", 0, 1, 0, 0);
    step("p_tick1", 1, 0, 0, 0);
    chk("pause.blank", 16'(o_blank), 16'h000F);
    step("p_tick0", 1, 0, 0, 0);
    step("p_resume", 0, 1, 0, 0);
    step("p_runtick", 1, 0, 0, 0);
    step("p_pause2", 0, 1, 0, 0);
    step("p_cancel", 0, 0, 1, 0);
    chk("cancel.preset", o_preset, 16'h0100);

    // 6: silence alarm, button priority, mid-run reset
    step("s_start", 0, 1, 0, 0);
    z_lvl = 1;
    step("s_expire", 0, 0, 0, 0);
    step("s_silence", 0, 0, 0, 1);
    chk("silence.state", 16'(o_state), 16'h0000);
    z_lvl = 0;
    step("prio", 0, 1, 1, 1);
    chk("prio.state", 16'(o_state), 16'h0003);
    step("prio_tick", 1, 0, 0, 0);
    do_reset(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
